// File: rtl/ro_race_controller.sv
// rtl/ro_race_controller.sv - sequencing master for the ring-oscillator race counter pair
// Runs NBITS races per challenge and returns one response bit per race over valid/ready.
module ro_race_controller #(
    parameter int NBITS   = 8,
    parameter int CW      = 4,
    parameter int SELW    = 3,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic [SELW-1:0]        CHAL,
    output logic                   BUSY,
    output logic [SELW-1:0]        RO_SEL,
    output logic                   CNT_RST,
    output logic                   CNT_EN,
    input  logic [CW-1:0]          COUNT1,
    input  logic [CW-1:0]          COUNT2,
    output logic [NBITS-1:0]       RESP,
    output logic                   RESP_VALID,
    input  logic                   RESP_READY,
    output logic [$clog2(NBITS):0] TIE_CNT,
    output logic                   TMO
);

    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int TW = $clog2((TIMEOUT > SETTLE) ? TIMEOUT : SETTLE) + 1;

    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NBITS - 1);
    localparam logic [CW-1:0] SAT          = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RACE,
        S_HOLD,
        S_CMP,
        S_OUT
    } state_t;

    state_t                 state_q;
    logic [SELW-1:0]        ro_sel_q;
    logic [IW-1:0]          idx_q;
    logic [TW-1:0]          tmr_q;
    logic [NBITS-1:0]       resp_q;
    logic [$clog2(NBITS):0] tie_q;
    logic                   tmo_q;
    logic                   busy_q;
    logic                   cnt_rst_q;
    logic                   cnt_en_q;
    logic                   valid_q;
    logic [CW-1:0]          c1_meta_q, c1_sync_q;
    logic [CW-1:0]          c2_meta_q, c2_sync_q;
    logic                   saturated;

    // Only the second synchroniser stage is ever looked at.
    assign saturated = (c1_sync_q == SAT) || (c2_sync_q == SAT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            ro_sel_q  <= '0;
            idx_q     <= '0;
            tmr_q     <= '0;
            resp_q    <= '0;
            tie_q     <= '0;
            tmo_q     <= 1'b0;
            busy_q    <= 1'b0;
            cnt_rst_q <= 1'b1;
            cnt_en_q  <= 1'b0;
            valid_q   <= 1'b0;
            c1_meta_q <= '0;
            c1_sync_q <= '0;
            c2_meta_q <= '0;
            c2_sync_q <= '0;
        end else begin
            c1_meta_q <= COUNT1;
            c1_sync_q <= c1_meta_q;
            c2_meta_q <= COUNT2;
            c2_sync_q <= c2_meta_q;
            case (state_q)
                S_IDLE: begin
                    cnt_rst_q <= 1'b1;
                    cnt_en_q  <= 1'b0;
                    if (START) begin
                        ro_sel_q <= CHAL;
                        idx_q    <= '0;
                        resp_q   <= '0;
                        tie_q    <= '0;
                        tmo_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        tmr_q    <= '0;
                        state_q  <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (tmr_q == SETTLE_LAST) begin
                        tmr_q     <= '0;
                        cnt_rst_q <= 1'b0;
                        cnt_en_q  <= 1'b1;
                        state_q   <= S_RACE;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                S_RACE: begin
                    if (saturated || tmr_q == TIMEOUT_LAST) begin
                        if (!saturated) begin
                            tmo_q <= 1'b1;
                        end
                        tmr_q    <= '0;
                        cnt_en_q <= 1'b0;
                        state_q  <= S_HOLD;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                S_HOLD: begin
                    // Counter is frozen here so the synchroniser catches its final values.
                    if (tmr_q == SETTLE_LAST) begin
                        tmr_q   <= '0;
                        state_q <= S_CMP;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                S_CMP: begin
                    resp_q[idx_q] <= (c1_sync_q > c2_sync_q);
                    if (c1_sync_q == c2_sync_q) begin
                        tie_q <= tie_q + ($clog2(NBITS)+1)'(1);
                    end
                    cnt_rst_q <= 1'b1;
                    if (idx_q == IDX_LAST) begin
                        valid_q <= 1'b1;
                        state_q <= S_OUT;
                    end else begin
                        idx_q    <= idx_q + IW'(1);
                        ro_sel_q <= ro_sel_q + SELW'(1);
                        state_q  <= S_CLR;
                    end
                end
                S_OUT: begin
                    cnt_rst_q <= 1'b1;
                    cnt_en_q  <= 1'b0;
                    if (RESP_READY) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY       = busy_q;
    assign RO_SEL     = ro_sel_q;
    assign CNT_RST    = cnt_rst_q;
    assign CNT_EN     = cnt_en_q;
    assign RESP       = resp_q;
    assign RESP_VALID = valid_q;
    assign TIE_CNT    = tie_q;
    assign TMO        = tmo_q;

endmodule

// File: tb/tb_ro_race_controller.sv
// tb/tb_ro_race_controller.sv - randomized self-checking bench for ro_race_controller
// A behavioural counter pair ramps to per-race targets; expected results come from the targets.
module tb_ro_race_controller;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [2:0] CHAL = '0;
    logic       BUSY;
    logic [2:0] RO_SEL;
    logic       CNT_RST;
    logic       CNT_EN;
    logic [3:0] COUNT1 = '0;
    logic [3:0] COUNT2 = '0;
    logic [7:0] RESP;
    logic       RESP_VALID;
    logic       RESP_READY = 1'b0;
    logic [3:0] TIE_CNT;
    logic       TMO;

    int checks = 0;
    int failures = 0;

    logic [3:0] t1 [8];
    logic [3:0] t2 [8];
    logic [2:0] ro_log [8];
    int         race_idx = 0;
    logic       en_prev = 1'b0;

    ro_race_controller dut (
        .CLK(CLK), .RESET(RESET), .START(START), .CHAL(CHAL), .BUSY(BUSY),
        .RO_SEL(RO_SEL), .CNT_RST(CNT_RST), .CNT_EN(CNT_EN),
        .COUNT1(COUNT1), .COUNT2(COUNT2), .RESP(RESP), .RESP_VALID(RESP_VALID),
        .RESP_READY(RESP_READY), .TIE_CNT(TIE_CNT), .TMO(TMO)
    );

    always #5 CLK = ~CLK;

    // Counter pair: each count climbs one step per enabled cycle up to its race target.
    always @(posedge CLK) begin
        if (CNT_RST) begin
            COUNT1 <= '0;
            COUNT2 <= '0;
        end else if (CNT_EN && race_idx < 8) begin
            if (COUNT1 < t1[race_idx]) COUNT1 <= COUNT1 + 4'd1;
            if (COUNT2 < t2[race_idx]) COUNT2 <= COUNT2 + 4'd1;
        end
        if (CNT_EN && !en_prev && race_idx < 8) ro_log[race_idx] <= RO_SEL;
        if (!BUSY) race_idx <= 0;
        else if (!CNT_EN && en_prev) race_idx <= race_idx + 1;
        en_prev <= CNT_EN;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(output logic [7:0] r, output logic [3:0] tie, output logic tmo);
        r = '0;
        tie = '0;
        tmo = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (t1[k] > t2[k]) r[k] = 1'b1;
            else if (t1[k] == t2[k]) tie = tie + 4'd1;
            if (t1[k] != 4'hF && t2[k] != 4'hF) tmo = 1'b1;
        end
    endtask

    task automatic set_all(input logic [3:0] a, input logic [3:0] b);
        for (int k = 0; k < 8; k++) begin
            t1[k] = a;
            t2[k] = b;
        end
    endtask

    task automatic set_random();
        int r;
        for (int k = 0; k < 8; k++) begin
            r = $urandom_range(0, 7);
            if (r < 3) begin
                t1[k] = 4'hF;
                t2[k] = 4'($urandom_range(0, 15));
            end else if (r < 6) begin
                t2[k] = 4'hF;
                t1[k] = 4'($urandom_range(0, 15));
            end else begin
                t1[k] = 4'($urandom_range(0, 14));
                t2[k] = 4'($urandom_range(0, 14));
            end
        end
    endtask

    task automatic start_chal(input logic [2:0] c);
        @(negedge CLK);
        START = 1'b1;
        CHAL = c;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!RESP_VALID && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_valid_timeout"}, 32'(RESP_VALID), 32'd1);
    endtask

    task automatic wait_race(input int k, input string tag);
        int n;
        n = 0;
        while (!(race_idx == k && CNT_EN) && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_race_timeout"}, 32'(race_idx == k && CNT_EN), 32'd1);
    endtask

    // Checks the presented response against the model; handshake with optional same-edge START.
    task automatic finish_chal(input logic [2:0] c, input string tag, input logic start_on_hs);
        logic [7:0]  er;
        logic [3:0]  et;
        logic        em;
        logic [23:0] got_log, exp_log;
        model(er, et, em);
        wait_valid(tag);
        check({tag, "_resp"}, 32'(RESP), 32'(er));
        check({tag, "_tie"}, 32'(TIE_CNT), 32'(et));
        check({tag, "_tmo"}, 32'(TMO), 32'(em));
        for (int k = 0; k < 8; k++) begin
            got_log[k*3 +: 3] = ro_log[k];
            exp_log[k*3 +: 3] = c + 3'(k);
        end
        check({tag, "_ro_sel"}, 32'(got_log), 32'(exp_log));
        RESP_READY = 1'b1;
        START = start_on_hs;
        @(posedge CLK);
        #1;
        check({tag, "_hs_valid"}, 32'(RESP_VALID), 32'd0);
        check({tag, "_hs_busy"}, 32'(BUSY), 32'd0);
        @(negedge CLK);
        RESP_READY = 1'b0;
        START = 1'b0;
        @(posedge CLK);
        #1;
        check({tag, "_idle_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_resp_kept"}, 32'(RESP), 32'(er));
    endtask

    initial begin
        logic [7:0] held;
        logic [2:0] c;
        int         seen;
        set_all(4'd0, 4'd0);
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("rst_cnt_rst", 32'(CNT_RST), 32'd1);
        check("rst_cnt_en", 32'(CNT_EN), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_valid", 32'(RESP_VALID), 32'd0);
        check("rst_resp", 32'(RESP), 32'd0);
        check("rst_sel", 32'(RO_SEL), 32'd0);
        check("rst_tie_tmo", {TIE_CNT, TMO}, 32'd0);

        set_all(4'd15, 4'd9);
        start_chal(3'd3);
        #1;
        check("start_busy", 32'(BUSY), 32'd1);
        finish_chal(3'd3, "c1_fast", 1'b1);

        for (int k = 0; k < 8; k++) begin
            t1[k] = (k % 2 == 0) ? 4'd15 : 4'd9;
            t2[k] = (k % 2 == 0) ? 4'd9 : 4'd15;
        end
        start_chal(3'd6);
        finish_chal(3'd6, "alternate", 1'b0);

        set_all(4'd5, 4'd5);
        start_chal(3'd1);
        finish_chal(3'd1, "tie_timeout", 1'b0);

        set_random();
        start_chal(3'd2);
        wait_valid("hold");
        held = RESP;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            START = (n == 10);
            CHAL = 3'd7;
            check("hold_valid", 32'(RESP_VALID), 32'd1);
            check("hold_resp", 32'(RESP), 32'(held));
        end
        START = 1'b0;
        finish_chal(3'd2, "hold", 1'b0);

        set_random();
        c = 3'($urandom_range(0, 7));
        start_chal(c);
        wait_race(2, "busy_start");
        @(negedge CLK);
        START = 1'b1;
        CHAL = c + 3'd4;
        @(negedge CLK);
        START = 1'b0;
        finish_chal(c, "busy_start", 1'b0);

        set_all(4'd15, 4'd3);
        start_chal(3'd0);
        wait_race(1, "mid_rst");
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("mid_rst_en", 32'(CNT_EN), 32'd0);
        check("mid_rst_rst", 32'(CNT_RST), 32'd1);
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        check("mid_rst_resp", {RESP, RESP_VALID}, 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        seen = 0;
        repeat (300) begin
            @(negedge CLK);
            if (RESP_VALID || BUSY) seen++;
        end
        check("mid_rst_dropped", 32'(seen), 32'd0);

        for (int r = 0; r < 6; r++) begin
            set_random();
            c = 3'($urandom_range(0, 7));
            start_chal(c);
            finish_chal(c, "random", r[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
